// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access size codes,
// controller FSM states and the wait-state counter width.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane logic: store byte enables and lane replication,
// load lane extraction with sign/zero extension, and fault decode.
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wlanes,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_outOfRange;

  assign w_byte       = i_rword[{i_adr[1:0], 3'b000} +: 8];
  assign w_half       = i_adr[1] ? i_rword[31:16] : i_rword[15:0];
  assign w_outOfRange = (i_adr[31:2] >= 30'(DEPTH));

  assign o_fault = (i_size == 2'b11)
                 | ((i_size == SIZE_H) & i_adr[0])
                 | ((i_size == SIZE_W) & (|i_adr[1:0]))
                 | w_outOfRange;

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    o_be     = 4'b0000;
    o_wlanes = i_wdata;
    o_rdata  = 32'h0;
    case (i_size)
      SIZE_B: begin
        o_be     = 4'b0001 << i_adr[1:0];
        o_wlanes = {4{i_wdata[7:0]}};
        o_rdata  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_be     = i_adr[1] ? 4'b1100 : 4'b0011;
        o_wlanes = {2{i_wdata[15:0]}};
        o_rdata  = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      SIZE_W: begin
        o_be    = 4'b1111;
        o_rdata = i_rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with valid/ready request/response handshake,
// alignment/range fault checking and programmable response wait states.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [1:0]            ReqSize,
  input  logic                  ReqUnsigned,
  input  logic [31:0]           DataAdr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic                  RespErr,
  output logic [DATA_WIDTH-1:0] ReadData
);

  if (DATA_WIDTH != 32) begin : g_badWidth
    $error("dmem_ctrl: DATA_WIDTH must be 32");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("dmem_ctrl: DEPTH must be a power of two and at least 4");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_badWait
    $error("dmem_ctrl: WAIT_STATES must be in 0..15");
  end

  localparam int ADR_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [31:0]           r_mem [DEPTH];
  state_t                r_state;
  state_t                w_nextState;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_nextCnt;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [ADR_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_rdataFmt;
  logic             w_fault;
  logic             w_accept;

  assign w_idx    = DataAdr[ADR_W+1:2];
  assign w_accept = ReqValid & (r_state == ST_IDLE);

  dmem_lane_fmt #(.DEPTH(DEPTH)) u_laneFmt (
    .i_size     (ReqSize),
    .i_unsigned (ReqUnsigned),
    .i_adr      (DataAdr),
    .i_wdata    (WriteData),
    .i_rword    (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wlanes   (w_wlanes),
    .o_rdata    (w_rdataFmt),
    .o_fault    (w_fault)
  );

  // Memory is not reset; an edge with RST high must never commit a store.
  always_ff @(posedge CLK) begin
    if (!RST && w_accept && ReqWrite && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_nextState = ST_WAIT;
            w_nextCnt   = WAIT_LOAD;
          end else begin
            w_nextState = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_nextState = ST_RESP;
        else             w_nextCnt   = r_cnt - 1'b1;
      end
      ST_RESP: begin
        if (RespReady) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_accept) begin
        r_err   <= w_fault;
        r_rdata <= (ReqWrite || w_fault) ? 32'h0 : w_rdataFmt;
      end else if (r_state == ST_RESP && RespReady) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  assign ReqReady  = (r_state == ST_IDLE);
  assign RespValid = (r_state == ST_RESP);
  assign RespErr   = r_err;
  assign ReadData  = r_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: two instances (0 and 3 wait states)
// driven by directed and random requests against a byte-level memory model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS0   = 0;
  localparam int WS1   = 3;

  logic        clk;
  logic        rst         [2];
  logic        reqValid    [2];
  logic        reqReady    [2];
  logic        reqWrite    [2];
  logic [1:0]  reqSize     [2];
  logic        reqUnsigned [2];
  logic [31:0] dataAdr     [2];
  logic [31:0] writeData   [2];
  logic        respValid   [2];
  logic        respReady   [2];
  logic        respErr     [2];
  logic [31:0] readData    [2];

  logic [7:0] refMem [2][4*DEPTH];
  int vectors     = 0;
  int miscompares = 0;

  dmem_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .CLK(clk), .RST(rst[0]), .ReqValid(reqValid[0]), .ReqReady(reqReady[0]),
    .ReqWrite(reqWrite[0]), .ReqSize(reqSize[0]), .ReqUnsigned(reqUnsigned[0]),
    .DataAdr(dataAdr[0]), .WriteData(writeData[0]), .RespValid(respValid[0]),
    .RespReady(respReady[0]), .RespErr(respErr[0]), .ReadData(readData[0])
  );

  dmem_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .CLK(clk), .RST(rst[1]), .ReqValid(reqValid[1]), .ReqReady(reqReady[1]),
    .ReqWrite(reqWrite[1]), .ReqSize(reqSize[1]), .ReqUnsigned(reqUnsigned[1]),
    .DataAdr(dataAdr[1]), .WriteData(writeData[1]), .RespValid(respValid[1]),
    .RespReady(respReady[1]), .RespErr(respErr[1]), .ReadData(readData[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int waitStates(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one request, optionally pokes ReqValid during the wait phase,
  // optionally stalls the response, and reports data, error and latency.
  task automatic applyStimulus(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                               input logic [31:0] adr, input logic [31:0] wd,
                               input int holdCycles, input bit pulse,
                               output logic [31:0] rd, output logic err, output int lat);
    int guard = 0;
    @(negedge clk);
    while (reqReady[d] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    reqValid[d] = 1'b1; reqWrite[d] = wr; reqSize[d] = sz;
    reqUnsigned[d] = uns; dataAdr[d] = adr; writeData[d] = wd;
    @(posedge clk); #1;
    reqValid[d]  = 1'b0;
    dataAdr[d]   = $urandom;
    writeData[d] = $urandom;
    if (pulse) begin
      reqValid[d] = 1'b1; reqWrite[d] = 1'b1; reqSize[d] = SIZE_W;
      dataAdr[d] = 32'h44; writeData[d] = 32'hBAD0BAD0;
    end
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (pulse && lat == 1) checkOutput("wait_req_ready", {31'b0, reqReady[d]}, 32'h0);
      if (pulse && lat == 2) reqValid[d] = 1'b0;
      if (respValid[d] === 1'b1) break;
    end
    reqValid[d] = 1'b0;
    if (respValid[d] !== 1'b1) begin
      lat = -1; rd = 'x; err = 1'bx;
    end else begin
      rd  = readData[d];
      err = respErr[d];
      for (int h = 0; h < holdCycles; h++) begin
        @(negedge clk);
        checkOutput("hold_data", readData[d], rd);
        checkOutput("hold_req_ready", {31'b0, reqReady[d]}, 32'h0);
        checkOutput("hold_resp_valid", {31'b0, respValid[d]}, 32'h1);
      end
    end
    respReady[d] = 1'b1;
    @(posedge clk); #1;
    respReady[d] = 1'b0;
  endtask

  // Reference behaviour: byte-addressed memory, little-endian lanes.
  task automatic doOp(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] adr, input logic [31:0] wd,
                      input int hold, input bit pulse, input string tag,
                      output logic [31:0] rd, output logic err);
    int          n;
    bit          fault;
    logic [31:0] expRd;
    longint      v;
    int          lat;
    n     = 1 << sz;
    fault = (sz == 2'b11) || ((adr % n) != 0) || ((adr >> 2) >= DEPTH);
    expRd = 32'h0;
    if (!fault && !wr) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(refMem[d][int'(adr) + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      expRd = v[31:0];
    end
    applyStimulus(d, wr, sz, uns, adr, wd, hold, pulse, rd, err, lat);
    checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, fault});
    checkOutput({tag, "_data"}, rd, expRd);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(1 + waitStates(d)));
    if (wr && !fault)
      for (int i = 0; i < n; i++) refMem[d][int'(adr) + i] = wd[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] adr;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqSize[d] = SIZE_W;
      reqUnsigned[d] = 1'b0; dataAdr[d] = '0; writeData[d] = '0; respReady[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_req_ready", {31'b0, reqReady[d]}, 32'h1);
      checkOutput("rst_resp_valid", {31'b0, respValid[d]}, 32'h0);
      checkOutput("rst_resp_err", {31'b0, respErr[d]}, 32'h0);
      checkOutput("rst_read_data", readData[d], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    $display("[TB] reset released");

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++)
        doOp(d, 1, SIZE_W, 0, 32'(4 * w), $urandom, 0, 0, "fill", rd, err);

    doOp(0, 1, SIZE_W, 0, 32'h10, 32'hDEADBEEF, 0, 0, "st_w10", rd, err);
    doOp(0, 0, SIZE_W, 0, 32'h10, 32'h0, 0, 0, "ld_w10", rd, err);
    checkOutput("ld_w10_const", rd, 32'hDEADBEEF);

    doOp(0, 1, SIZE_W, 0, 32'h20, 32'h80F07F01, 0, 0, "st_w20", rd, err);
    doOp(0, 0, SIZE_B, 0, 32'h21, 32'h0, 0, 0, "ld_b21", rd, err);
    checkOutput("ld_b21_const", rd, 32'h0000007F);
    doOp(0, 0, SIZE_B, 0, 32'h23, 32'h0, 0, 0, "ld_b23", rd, err);
    checkOutput("ld_b23_const", rd, 32'hFFFFFF80);
    doOp(0, 0, SIZE_B, 1, 32'h23, 32'h0, 0, 0, "ld_bu23", rd, err);
    checkOutput("ld_bu23_const", rd, 32'h00000080);
    doOp(0, 0, SIZE_H, 0, 32'h22, 32'h0, 0, 0, "ld_h22", rd, err);
    checkOutput("ld_h22_const", rd, 32'hFFFF80F0);
    doOp(0, 0, SIZE_H, 1, 32'h22, 32'h0, 0, 0, "ld_hu22", rd, err);
    checkOutput("ld_hu22_const", rd, 32'h000080F0);

    doOp(0, 1, SIZE_W, 0, 32'h30, 32'h11223344, 0, 0, "st_w30", rd, err);
    doOp(0, 1, SIZE_B, 0, 32'h32, 32'h000000AA, 0, 0, "st_b32", rd, err);
    doOp(0, 0, SIZE_W, 0, 32'h30, 32'h0, 0, 0, "ld_w30a", rd, err);
    checkOutput("ld_w30a_const", rd, 32'h11AA3344);
    doOp(0, 1, SIZE_H, 0, 32'h30, 32'h0000BEEF, 0, 0, "st_h30", rd, err);
    doOp(0, 0, SIZE_W, 0, 32'h30, 32'h0, 0, 0, "ld_w30b", rd, err);
    checkOutput("ld_w30b_const", rd, 32'h11AABEEF);

    doOp(0, 1, SIZE_W, 0, 32'h31, 32'hCAFEF00D, 0, 0, "flt_st_w31", rd, err);
    checkOutput("flt_st_w31_const", {31'b0, err}, 32'h1);
    doOp(0, 0, SIZE_W, 0, 32'h30, 32'h0, 0, 0, "ld_w30c", rd, err);
    checkOutput("ld_w30c_const", rd, 32'h11AABEEF);
    doOp(0, 0, SIZE_H, 0, 32'h33, 32'h0, 0, 0, "flt_ld_h33", rd, err);
    checkOutput("flt_ld_h33_const", {31'b0, err}, 32'h1);
    doOp(0, 0, 2'b11, 0, 32'h10, 32'h0, 0, 0, "flt_size11", rd, err);
    doOp(0, 0, SIZE_W, 0, 32'(4 * DEPTH), 32'h0, 0, 0, "flt_range", rd, err);
    checkOutput("flt_range_const", {31'b0, err}, 32'h1);

    $display("[TB] wait-state instance");
    doOp(1, 1, SIZE_W, 0, 32'h40, 32'h12345678, 0, 0, "ws_st_w40", rd, err);
    doOp(1, 1, SIZE_W, 0, 32'h44, 32'h00000000, 0, 0, "ws_st_w44", rd, err);
    doOp(1, 0, SIZE_W, 0, 32'h40, 32'h0, 5, 0, "ws_hold", rd, err);
    checkOutput("ws_hold_const", rd, 32'h12345678);
    doOp(1, 0, SIZE_W, 0, 32'h40, 32'h0, 0, 1, "ws_pulse", rd, err);
    doOp(1, 0, SIZE_W, 0, 32'h44, 32'h0, 0, 0, "ws_ld_w44", rd, err);
    checkOutput("ws_ld_w44_const", rd, 32'h0);

    $display("[TB] reset during wait");
    @(negedge clk);
    reqValid[1] = 1'b1; reqWrite[1] = 1'b0; reqSize[1] = SIZE_W; dataAdr[1] = 32'h40;
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    @(negedge clk);
    checkOutput("mid_wait_req_ready", {31'b0, reqReady[1]}, 32'h0);
    rst[1] = 1'b1;
    #1;
    checkOutput("mid_rst_req_ready", {31'b0, reqReady[1]}, 32'h1);
    checkOutput("mid_rst_resp_valid", {31'b0, respValid[1]}, 32'h0);
    checkOutput("mid_rst_resp_err", {31'b0, respErr[1]}, 32'h0);
    checkOutput("mid_rst_read_data", readData[1], 32'h0);
    reqValid[1] = 1'b1; reqWrite[1] = 1'b1; reqSize[1] = SIZE_W;
    dataAdr[1] = 32'h40; writeData[1] = 32'h0;
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    doOp(1, 0, SIZE_W, 0, 32'h40, 32'h0, 0, 0, "post_rst_ld", rd, err);
    checkOutput("post_rst_ld_const", rd, 32'h12345678);

    $display("[TB] random traffic");
    for (int k = 0; k < 260; k++) begin
      int d;
      d = (k < 200) ? 0 : 1;
      if ($urandom_range(15) == 0) adr = 32'(4 * DEPTH) + $urandom_range(4095);
      else                         adr = $urandom_range(4 * 64 - 1);
      doOp(d, 1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
           adr, $urandom, 0, 0, "rnd", rd, err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the single-cycle RISC-V core's load/store path, the successor to the plain word-addressed data RAM. It adds byte/halfword/word accesses with RISC-V lane placement and sign/zero extension, alignment and range checking, and a valid/ready request-response handshake. It also has programmable wait states, so the core can be exercised against slower memory timing.

## Interface
- DATA_WIDTH, 32: data bus width. Only 32 is supported; any other value is an elaboration error.
- DEPTH, 256: number of words. Must be a power of two, ≥4.
- WAIT_STATES, 0: extra cycles inserted between request accept and response. Range 0..15.
- CLK input 1: single clock; all state updates on its rising edge.
- RST input 1: asynchronous, active-high reset.
- ReqValid input 1: request present.
- ReqReady output 1: block can accept a request.
- ReqWrite input 1: 1 = store, 0 = load.
- ReqSize input 2: 00 byte, 01 half, 10 word, 11 illegal (funct3[1:0]).
- ReqUnsigned input 1: zero-extend loads (funct3[2]).
- DataAdr input 32: byte address.
- WriteData input 32: store data, right-aligned (lane 0).
- RespValid output 1: response present.
- RespReady input 1: consumer takes response.
- RespErr output 1: request faulted (misaligned, out of range or illegal size).
- ReadData output 32: extended load data; 0 for stores and faults.

## Operation
- FSM states:
  - IDLE: ReqReady=1. Accept when ReqValid && ReqReady. Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: a counter loads WAIT_STATES-1 on accept and decrements each cycle. Go to RESP when it reaches 0.
  - RESP: RespValid=1. Go to IDLE on RespReady.
- ReqReady=0 in WAIT and RESP. One request is outstanding at most.
- Fault check is evaluated at accept:
  - ReqSize=11 is a fault.
  - Half with DataAdr[0]≠0 is a fault.
  - Word with DataAdr[1:0]≠0 is a fault.
  - Word index DataAdr[31:2] ≥ DEPTH is a fault.
  - A faulting request writes nothing and returns RespErr=1, ReadData=0.
- Store: on the accept edge, only the addressed lanes are written.
  - Byte: lane DataAdr[1:0] gets WriteData[7:0].
  - Half: lanes {DataAdr[1],0}..+1 get WriteData[15:0].
  - Word: all lanes are written.
- Load: the selected word is read and formatted at the accept edge into a response register.
  - Extraction uses the same lane selection as stores.
  - Byte and half results sign-extend unless ReqUnsigned=1. Word ignores ReqUnsigned.
- The response register holds stable while RespValid=1 && RespReady=0.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: FSM=IDLE, ReqReady=1, RespValid=0, RespErr=0, ReadData=0, wait counter=0.
- Accept-to-RespValid latency is 1+WAIT_STATES cycles.
- Minimum request spacing is 2+WAIT_STATES cycles, achieved when RespReady is held at 1.
- The store is visible to a load accepted in any later cycle.
- Inputs are sampled only on the accept edge. Changes to DataAdr or WriteData afterwards have no effect.
- RST asserted mid-operation clears the FSM and outputs asynchronously and drops the pending response. No write occurs on an edge where RST=1. Memory words written earlier are retained.
- ReqValid while ReqReady=0 is ignored; the requester must hold it.

## Structure
- dmem_pkg holds:
  - size encodings SIZE_B, SIZE_H, SIZE_W;
  - the FSM state enum (ST_IDLE, ST_WAIT, ST_RESP);
  - the WAIT_STATES counter width (4).
- Sub-module dmem_lane_fmt is purely combinational and contains:
  - store byte-enable generation and lane shifting;
  - load lane extraction and extension;
  - fault decode.
- dmem_ctrl holds the RAM array, FSM, counter and response registers.

## Test plan
- Word store then load, WAIT_STATES=0:
  - Store 0xDEADBEEF to 0x10, then load word from 0x10.
  - Expect ReadData=0xDEADBEEF, RespErr=0, RespValid exactly 1 cycle after accept.
- Byte and half extension:
  - Word 0x80F07F01 at 0x20.
  - Load byte from 0x21 → 0x0000007F; from 0x23 → 0xFFFFFF80.
  - Load byte unsigned from 0x23 → 0x00000080.
  - Load half from 0x22 → 0xFFFF80F0; load half unsigned from 0x22 → 0x000080F0.
- Partial store:
  - Word 0x11223344 at 0x30.
  - Store byte 0xAA to 0x32, then load word → 0x11AA3344.
  - Store half 0xBEEF to 0x30, then load word → 0x11AABEEF.
- Faults:
  - Word store at 0x31 → RespErr=1, memory unchanged.
  - Half load at 0x33 → RespErr=1, ReadData=0.
  - ReqSize=11 → RespErr=1.
  - Word address 4*DEPTH → RespErr=1.
- Wait states and backpressure, WAIT_STATES=3:
  - RespValid rises 4 cycles after accept.
  - Hold RespReady=0 for 5 cycles: ReadData stays stable and ReqReady stays 0.
  - A ReqValid pulse during WAIT is not accepted.
- Reset mid-operation:
  - Assert RST during WAIT.
  - Outputs go to reset values immediately and the next request is accepted normally.
  - A word written before reset still reads back.
